min_search_ctrl: RTL and testbench
==================================

Name: min_search_ctrl

Overview:
- Sequencing controller that finds the minimum of a length-programmed stream of unsigned samples, and the index where that minimum occurs.
- Accepts one sample per cycle over a valid/ready handshake.
- Folds each sample through a two-input minimum comparator.
- Reports the result with a one-cycle done pulse.
- Sits between a sample source, such as a FIFO or register bank, and any consumer that needs a running or final minimum.

Parameters:
- WIDTH, 8, sample and result width in bits (unsigned).
- MAX_LEN, 16, maximum samples per search.
- LEN_W, 5, width of length and index fields; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a search; sampled only in IDLE.
- len  in  LEN_W  number of samples in the search; captured with start.
- in_valid  in  1  source has a sample on in_data.
- in_data  in  WIDTH  sample value, unsigned.
- in_ready  out  1  controller accepts a sample this cycle.
- busy  out  1  high from the accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when min_val and min_idx are final.
- empty  out  1  high with done when the search was run with len==0.
- min_val  out  WIDTH  minimum sample of the last completed search.
- min_idx  out  LEN_W  zero-based index of the first occurrence of min_val.

Behaviour:
- Reset, synchronous and active-high (state = IDLE):
  - in_ready=0, busy=0, done=0, empty=0.
  - min_val = all ones; min_idx=0; internal counter and length = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with len in 1..MAX_LEN: capture len, clear counter, go to RUN.
  - start=1 with len==0: go to DONE with empty=1, min_val = all ones, min_idx=0.
  - start=1 with len>MAX_LEN: clamp len to MAX_LEN.
- RUN:
  - in_ready=1 and busy=1.
  - A sample is accepted when in_valid && in_ready.
  - Accepted sample at count==0: load min_val=in_data, min_idx=0.
  - Later accepted samples: update only if in_data < min_val (strict compare), so ties keep the earliest index. The comparator sub-module makes this decision.
  - The counter increments on every accept.
  - When the accepted sample has count==len-1, go to DONE.
  - in_valid=0 stalls with no state change and no timeout.
- DONE:
  - done=1 for exactly one cycle, busy=1, in_ready=0; then return to IDLE.
- Latency: done is asserted the cycle after the last sample is accepted. The minimum total for len=N with in_valid held high is N+1 cycles after the start cycle.
- min_val and min_idx hold their values from DONE until the next accepted sample of a new search.
- While busy, start is ignored: no restart and no length change.
- A start in the same cycle as done is ignored. start is re-sampled only once the block is in IDLE.
- Samples offered while in_ready=0 are not consumed; the source must hold them.
- rst mid-RUN: return to reset values on the next edge; a partial result is discarded and done is not pulsed.
- Arithmetic:
  - All comparisons are unsigned WIDTH-bit.
  - The counter is LEN_W bits and never wraps, because len ≤ MAX_LEN < 2^LEN_W.

Decomposition:
- Shared package: state encoding typedef (IDLE/RUN/DONE), default WIDTH/MAX_LEN/LEN_W constants, and the MIN_INIT all-ones constant.
- One sub-module: min2_unit.
  - Purely combinational, parameterised by WIDTH.
  - Inputs: a and b. Outputs: min value, plus a flag "b strictly less than a".
  - It is instantiated once; the controller uses the flag for the index update.

Test Plan:
- Basic:
  - Stimulus: start, len=4; samples 0x30, 0x12, 0x55, 0x20 with in_valid high.
  - Required: done pulses 5 cycles after the start cycle; min_val=0x12, min_idx=1, empty=0.
- Ties and extremes:
  - Stimulus: len=5; samples 0x07, 0xFF, 0x07, 0x00, 0x00.
  - Required: min_val=0x00, min_idx=3 (first occurrence).
- Backpressure and stalls:
  - Stimulus: len=3; in_valid toggles 1,0,0,1,0,1 with data 0x40, -, -, 0x10, -, 0x90.
  - Required: exactly 3 accepts; min_val=0x10, min_idx=1; done one cycle after the third accept.
- Boundary lengths:
  - len=0: done the cycle after start with empty=1, min_val=0xFF.
  - len=1 with sample 0xA5: min_val=0xA5, min_idx=0.
  - len=20 (>MAX_LEN): exactly 16 samples accepted.
- Reset mid-operation:
  - Stimulus: len=4; assert rst after 2 accepts.
  - Required: next cycle in_ready=0, busy=0, min_val=0xFF, no done. A fresh search afterwards gives a correct result.
- Start while busy:
  - Stimulus: start, len=6 pulsed during RUN of a len=3 search.
  - Required: the pulse is ignored; the original 3-sample result is reported; the block returns to IDLE.

Source files
------------

// File: rtl/min_search_ctrl_pkg.sv
// Shared types and defaults for the min_search_ctrl block.
package min_search_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefMaxLen = 16;
  localparam int unsigned DefLenW   = 5;

  localparam logic [DefWidth-1:0] MIN_INIT = '1;

endpackage

// File: rtl/min_search_ctrl_min2.sv
// Two-input unsigned minimum; flags when b is strictly below a so ties keep a.
module min2_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] min_o,
  output logic             b_lt_a_o
);

  assign b_lt_a_o = (b_i < a_i);
  assign min_o    = b_lt_a_o ? b_i : a_i;

endmodule

// File: rtl/min_search_ctrl.sv
// Length-programmed minimum search over a valid/ready sample stream with done pulse.
module min_search_ctrl
  import min_search_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned LEN_W   = DefLenW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             empty,
  output logic [WIDTH-1:0] min_val,
  output logic [LEN_W-1:0] min_idx
);

  localparam logic [WIDTH-1:0] MinInit = {WIDTH{1'b1}};
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] min_val_q, min_val_d;
  logic [LEN_W-1:0] min_idx_q, min_idx_d;
  logic             empty_q, empty_d;

  logic             accept;
  logic [WIDTH-1:0] cmp_min;
  logic             cmp_b_lt_a;

  min2_unit #(
    .WIDTH(WIDTH)
  ) u_min2 (
    .a_i      (min_val_q),
    .b_i      (in_data),
    .min_o    (cmp_min),
    .b_lt_a_o (cmp_b_lt_a)
  );

  assign accept = (state_q == StRun) && in_valid;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    min_val_d = min_val_q;
    min_idx_d = min_idx_q;
    empty_d   = empty_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          if (len == '0) begin
            state_d   = StDone;
            empty_d   = 1'b1;
            len_d     = '0;
            min_val_d = MinInit;
            min_idx_d = '0;
          end else begin
            state_d = StRun;
            empty_d = 1'b0;
            len_d   = (len > LenMax) ? LenMax : len;
          end
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          // First sample seeds the result; later ones replace it only when strictly smaller.
          if (cnt_q == '0) begin
            min_val_d = in_data;
            min_idx_d = '0;
          end else if (cmp_b_lt_a) begin
            min_val_d = cmp_min;
            min_idx_d = cnt_q;
          end
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      min_val_q <= MinInit;
      min_idx_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      min_val_q <= min_val_d;
      min_idx_q <= min_idx_d;
      empty_q   <= empty_d;
    end
  end

  assign in_ready = (state_q == StRun);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign empty    = (state_q == StDone) && empty_q;
  assign min_val  = min_val_q;
  assign min_idx  = min_idx_q;

endmodule

// File: tb/tb_min_search_ctrl.sv
// Self-checking bench for min_search_ctrl: directed scenarios plus randomized searches.
module tb_min_search_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, busy, done, empty;
  logic [7:0] min_val;
  logic [4:0] min_idx;

  int asserts = 0;
  int fails   = 0;

  logic [7:0] samp [0:31];
  int         vpat [$];

  min_search_ctrl #(
    .WIDTH   (8),
    .MAX_LEN (16),
    .LEN_W   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .empty    (empty),
    .min_val  (min_val),
    .min_idx  (min_idx)
  );

  always #5 clk = ~clk;

  // Reference: minimum over the first min(len,16) samples, earliest index on ties.
  task automatic model(input int l, output int n, output logic [7:0] v, output logic [4:0] ix);
    n  = (l > 16) ? 16 : l;
    v  = 8'hFF;
    ix = '0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || int'(samp[i]) < int'(v)) begin
        v  = samp[i];
        ix = 5'(i);
      end
    end
  endtask

  // Drives one search from IDLE and records what the DUT did; cycle numbers count edges
  // after the start cycle.
  task automatic run_search(input int l, input int stall_pct, input int busy_start_cyc,
                            input bit start_on_done, output int n_acc, output int done_cyc,
                            output int last_acc, output logic [7:0] v, output logic [4:0] ix,
                            output logic emp, output logic done_after, output logic busy_after);
    int cyc;
    bit fin;
    bit acc;
    n_acc = 0; done_cyc = -1; last_acc = -1; fin = 0;
    v = 'x; ix = 'x; emp = 'x; done_after = 'x; busy_after = 'x;
    start = 1'b1;
    len   = 5'(l);
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
    cyc   = 1;
    while (!fin && cyc < 200) begin
      if (done) begin
        fin = 1; done_cyc = cyc; v = min_val; ix = min_idx; emp = empty;
        in_valid = 1'b0;
        start    = start_on_done;
        len      = 5'd3;
      end else begin
        if (vpat.size() > 0 && in_ready) in_valid = (vpat.pop_front() != 0);
        else in_valid = ($urandom_range(0, 99) >= stall_pct);
        in_data = in_valid ? samp[n_acc & 31] : 8'($urandom);
        start   = (cyc == busy_start_cyc);
        len     = start ? 5'd6 : 5'd0;
        acc     = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) begin
          last_acc = cyc;
          n_acc++;
        end
        cyc++;
      end
    end
    if (fin) begin
      @(posedge clk); #1;
      done_after = done;
      busy_after = busy;
    end else begin
      asserts++; fails++;
      $display("FAIL timeout: no done within 200 cycles (len=%0d)", l);
    end
    start = 1'b0; len = '0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    asserts++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    asserts++; if (empty !== 1'b0) begin fails++; $display("FAIL reset_empty got %b want 0", empty); end
    asserts++; if (min_val !== 8'hFF) begin fails++; $display("FAIL reset_min_val got %h want ff", min_val); end
    asserts++; if (min_idx !== 5'd0) begin fails++; $display("FAIL reset_min_idx got %0d want 0", min_idx); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n, dc, la; logic [7:0] v; logic [4:0] ix; logic e, da, ba;
    samp[0] = 8'h30; samp[1] = 8'h12; samp[2] = 8'h55; samp[3] = 8'h20;
    run_search(4, 0, -1, 0, n, dc, la, v, ix, e, da, ba);
    asserts++; if (n !== 4) begin fails++; $display("FAIL basic_accepts got %0d want 4", n); end
    asserts++; if (dc !== 5) begin fails++; $display("FAIL basic_latency got %0d want 5", dc); end
    asserts++; if (v !== 8'h12) begin fails++; $display("FAIL basic_min_val got %h want 12", v); end
    asserts++; if (ix !== 5'd1) begin fails++; $display("FAIL basic_min_idx got %0d want 1", ix); end
    asserts++; if (e !== 1'b0) begin fails++; $display("FAIL basic_empty got %b want 0", e); end
    asserts++; if (da !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b want 0", da); end
    asserts++; if (ba !== 1'b0) begin fails++; $display("FAIL basic_idle_after got %b want 0", ba); end
    asserts++; if (min_val !== 8'h12) begin fails++; $display("FAIL basic_hold got %h want 12", min_val); end
  endtask

  task automatic test_ties();
    int n, dc, la; logic [7:0] v; logic [4:0] ix; logic e, da, ba;
    samp[0] = 8'h07; samp[1] = 8'hFF; samp[2] = 8'h07; samp[3] = 8'h00; samp[4] = 8'h00;
    run_search(5, 0, -1, 0, n, dc, la, v, ix, e, da, ba);
    asserts++; if (v !== 8'h00) begin fails++; $display("FAIL ties_min_val got %h want 00", v); end
    asserts++; if (ix !== 5'd3) begin fails++; $display("FAIL ties_min_idx got %0d want 3", ix); end
  endtask

  task automatic test_backpressure();
    int n, dc, la; logic [7:0] v; logic [4:0] ix; logic e, da, ba;
    samp[0] = 8'h40; samp[1] = 8'h10; samp[2] = 8'h90;
    vpat = '{1, 0, 0, 1, 0, 1};
    run_search(3, 100, -1, 0, n, dc, la, v, ix, e, da, ba);
    asserts++; if (n !== 3) begin fails++; $display("FAIL bp_accepts got %0d want 3", n); end
    asserts++; if (v !== 8'h10) begin fails++; $display("FAIL bp_min_val got %h want 10", v); end
    asserts++; if (ix !== 5'd1) begin fails++; $display("FAIL bp_min_idx got %0d want 1", ix); end
    asserts++; if (dc !== 7) begin fails++; $display("FAIL bp_latency got %0d want 7", dc); end
    vpat.delete();
  endtask

  task automatic test_boundary();
    int n, dc, la, en; logic [7:0] v, ev; logic [4:0] ix, eix; logic e, da, ba;
    run_search(0, 0, -1, 0, n, dc, la, v, ix, e, da, ba);
    asserts++; if (dc !== 1) begin fails++; $display("FAIL len0_latency got %0d want 1", dc); end
    asserts++; if (e !== 1'b1) begin fails++; $display("FAIL len0_empty got %b want 1", e); end
    asserts++; if (v !== 8'hFF) begin fails++; $display("FAIL len0_min_val got %h want ff", v); end
    asserts++; if (n !== 0) begin fails++; $display("FAIL len0_accepts got %0d want 0", n); end
    samp[0] = 8'hA5;
    run_search(1, 0, -1, 0, n, dc, la, v, ix, e, da, ba);
    asserts++; if (v !== 8'hA5) begin fails++; $display("FAIL len1_min_val got %h want a5", v); end
    asserts++; if (ix !== 5'd0) begin fails++; $display("FAIL len1_min_idx got %0d want 0", ix); end
    for (int i = 0; i < 32; i++) samp[i] = 8'($urandom_range(1, 255));
    samp[18] = 8'h00;
    model(20, en, ev, eix);
    run_search(20, 0, -1, 0, n, dc, la, v, ix, e, da, ba);
    asserts++; if (n !== 16) begin fails++; $display("FAIL len20_accepts got %0d want 16", n); end
    asserts++; if (v !== ev) begin fails++; $display("FAIL len20_min_val got %h want %h", v, ev); end
    asserts++; if (ix !== eix) begin fails++; $display("FAIL len20_min_idx got %0d want %0d", ix, eix); end
  endtask

  task automatic test_reset_mid();
    int n, dc, la; logic [7:0] v; logic [4:0] ix; logic e, da, ba;
    int acc;
    samp[0] = 8'h33; samp[1] = 8'h22; samp[2] = 8'h11; samp[3] = 8'h44;
    start = 1'b1; len = 5'd4;
    @(posedge clk); #1;
    start = 1'b0; len = '0;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = samp[i];
      @(posedge clk); #1;
      acc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    asserts++; if (min_val !== 8'hFF) begin fails++; $display("FAIL rstmid_min_val got %h want ff", min_val); end
    asserts++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", done); end
    @(posedge clk); #1;
    samp[0] = 8'h60; samp[1] = 8'h50; samp[2] = 8'h08; samp[3] = 8'h08;
    run_search(4, 30, -1, 0, n, dc, la, v, ix, e, da, ba);
    asserts++; if (v !== 8'h08 || ix !== 5'd2) begin
      fails++; $display("FAIL rstmid_fresh got %h@%0d want 08@2", v, ix);
    end
  endtask

  task automatic test_start_while_busy();
    int n, dc, la; logic [7:0] v; logic [4:0] ix; logic e, da, ba;
    samp[0] = 8'h21; samp[1] = 8'h19; samp[2] = 8'h77;
    for (int i = 3; i < 8; i++) samp[i] = 8'h01;
    run_search(3, 0, 2, 1, n, dc, la, v, ix, e, da, ba);
    asserts++; if (n !== 3) begin fails++; $display("FAIL busy_accepts got %0d want 3", n); end
    asserts++; if (v !== 8'h19 || ix !== 5'd1) begin
      fails++; $display("FAIL busy_result got %h@%0d want 19@1", v, ix);
    end
    asserts++; if (ba !== 1'b0) begin fails++; $display("FAIL busy_start_on_done got %b want 0", ba); end
  endtask

  task automatic test_random();
    int n, dc, la, l, en; logic [7:0] v, ev; logic [4:0] ix, eix; logic e, da, ba;
    for (int it = 0; it < 30; it++) begin
      l = $urandom_range(0, 20);
      for (int i = 0; i < 32; i++) begin
        samp[i] = (it % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      end
      model(l, en, ev, eix);
      run_search(l, $urandom_range(0, 60), -1, 0, n, dc, la, v, ix, e, da, ba);
      asserts++; if (n !== en) begin fails++; $display("FAIL rnd%0d_accepts got %0d want %0d", it, n, en); end
      asserts++; if (v !== ev || ix !== eix) begin
        fails++; $display("FAIL rnd%0d_result got %h@%0d want %h@%0d", it, v, ix, ev, eix);
      end
      asserts++; if (e !== (en == 0)) begin fails++; $display("FAIL rnd%0d_empty got %b", it, e); end
      asserts++; if (dc !== ((en == 0) ? 1 : la + 1)) begin
        fails++; $display("FAIL rnd%0d_latency got %0d want %0d", it, dc, (en == 0) ? 1 : la + 1);
      end
      if ($urandom_range(0, 1) != 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
